sobel_edge_stream: RTL and testbench

- Streaming 3x3 Sobel edge detector for the 8-bit grayscale pixel stream produced by the camera capture path.
- Sits between the grayscale converter and the line buffer / bus-master DMA.
- Keeps two previous lines on chip, computes |gx|+|gy| per pixel and applies a threshold or saturated-magnitude output.
- Repacks the results four pixels per 32-bit word, using the grayscale word packing: first pixel in bits [7:0].

---
 rtl/sobel_edge_stream.sv | 212 +++++++++++++++++++++
 tb/tb_sobel_edge_stream.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_edge_stream.sv
// Streaming 3x3 Sobel edge detector, |gx|+|gy| magnitude, four output bytes packed per 32-bit word.
// Latency: word valid 3 cycles after the pixel carrying its 4th byte (or the end-of-line pixel).
// Backpressure: none; accepts one pixel per cycle with arbitrary gaps, output is a single-cycle pulse.
module sobel_edge_stream #(
  parameter int IMG_WIDTH = 640
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [10:0] i_threshold,
  input  logic        i_mode,
  input  logic [7:0]  i_pixel,
  input  logic        i_pixel_vld,
  input  logic        i_sof,
  input  logic        i_eol,
  output logic [31:0] o_edge_dat,
  output logic        o_edge_vld,
  output logic        o_edge_eol,
  output logic        o_over_length
);

  localparam int XW = $clog2(IMG_WIDTH) + 1;
  localparam int AW = $clog2(IMG_WIDTH);
  localparam logic [XW-1:0] X_MAX = XW'(IMG_WIDTH);

  // frame / position tracking
  logic          r_in_frame;
  logic [XW-1:0] r_x;
  logic [1:0]    r_y;      // row index saturating at 2: only "row < 2" matters
  logic [1:0]    r_pos;    // byte slot within the output word, never saturates
  logic          r_over_length;

  // stage 1: pixel registered alongside the synchronous line-buffer read
  logic          r_s1_vld, r_s1_wr, r_s1_mask, r_s1_eol, r_s1_sof;
  logic [7:0]    r_s1_pix;
  logic [AW-1:0] r_s1_addr;
  logic [1:0]    r_s1_pos;

  // line buffers and their read registers
  logic [7:0]    r_lb1 [IMG_WIDTH];   // row y-1
  logic [7:0]    r_lb2 [IMG_WIDTH];   // row y-2
  logic [7:0]    r_rd1, r_rd2;

  // stage 2: 3x3 window, index = column (2 = newest)
  logic [2:0][7:0] r_row0, r_row1, r_row2;
  logic          r_s2_vld, r_s2_mask, r_s2_eol, r_s2_sof;
  logic [1:0]    r_s2_pos;

  // stage 3: finished byte
  logic          r_s3_vld, r_s3_eol, r_s3_sof;
  logic [7:0]    r_s3_byte;
  logic [1:0]    r_s3_pos;

  // pack and output registers
  logic [31:0]   r_pack, r_edge_dat;
  logic          r_edge_vld, r_edge_eol;

  // stage 0 decode: startOfFrame forces this pixel to (0,0)
  logic          w_acc, w_over, w_fwd;
  logic [XW-1:0] w_x;
  logic [1:0]    w_y, w_pos;
  logic [AW-1:0] w_rd_addr;

  assign w_acc     = i_pixel_vld & (r_in_frame | i_sof);
  assign w_x       = i_sof ? '0 : r_x;
  assign w_y       = i_sof ? 2'd0 : r_y;
  assign w_pos     = i_sof ? 2'd0 : r_pos;
  assign w_over    = (w_x >= X_MAX);
  assign w_rd_addr = w_x[AW-1:0];
  // a 1-pixel line re-reads the column stage 1 is writing this very edge
  assign w_fwd     = r_s1_vld & r_s1_wr & (r_s1_addr == w_rd_addr);

  // counters, frame state, sticky over-length flag and stage-1 capture
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_in_frame    <= 1'b0;
      r_x           <= '0;
      r_y           <= 2'd0;
      r_pos         <= 2'd0;
      r_over_length <= 1'b0;
      r_s1_vld      <= 1'b0;
      r_s1_wr       <= 1'b0;
      r_s1_mask     <= 1'b0;
      r_s1_eol      <= 1'b0;
      r_s1_sof      <= 1'b0;
      r_s1_pix      <= 8'd0;
      r_s1_addr     <= '0;
      r_s1_pos      <= 2'd0;
    end else begin
      r_s1_vld <= w_acc;
      if (w_acc) begin
        r_in_frame    <= 1'b1;
        r_x           <= i_eol ? '0 : (w_over ? X_MAX : w_x + XW'(1));
        r_y           <= i_eol ? ((w_y == 2'd2) ? 2'd2 : w_y + 2'd1) : w_y;
        r_pos         <= i_eol ? 2'd0 : w_pos + 2'd1;
        r_over_length <= (r_over_length & ~i_sof) | w_over;
        r_s1_wr       <= ~w_over;
        r_s1_mask     <= (w_x < XW'(2)) | (w_y < 2'd2) | w_over;
        r_s1_eol      <= i_eol;
        r_s1_sof      <= i_sof;
        r_s1_pix      <= i_pixel;
        r_s1_addr     <= w_rd_addr;
        r_s1_pos      <= w_pos;
      end
    end
  end

  // line-buffer RAMs: read rows y-1/y-2 on accept, write back one cycle later
  always_ff @(posedge i_clk) begin
    if (r_s1_vld && r_s1_wr) begin
      r_lb1[r_s1_addr] <= r_s1_pix;
      r_lb2[r_s1_addr] <= r_rd1;
    end
    if (w_acc) begin
      r_rd1 <= w_fwd ? r_s1_pix : r_lb1[w_rd_addr];
      r_rd2 <= w_fwd ? r_rd1    : r_lb2[w_rd_addr];
    end
  end

  // window shift: one column per accepted pixel
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_row0    <= '0;
      r_row1    <= '0;
      r_row2    <= '0;
      r_s2_vld  <= 1'b0;
      r_s2_mask <= 1'b0;
      r_s2_eol  <= 1'b0;
      r_s2_sof  <= 1'b0;
      r_s2_pos  <= 2'd0;
    end else begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_row0    <= {r_rd2,    r_row0[2], r_row0[1]};
        r_row1    <= {r_rd1,    r_row1[2], r_row1[1]};
        r_row2    <= {r_s1_pix, r_row2[2], r_row2[1]};
        r_s2_mask <= r_s1_mask;
        r_s2_eol  <= r_s1_eol;
        r_s2_sof  <= r_s1_sof;
        r_s2_pos  <= r_s1_pos;
      end
    end
  end

  // Sobel arithmetic as unsigned positive/negative halves, then |a-b|
  logic [9:0]  w_gx_p, w_gx_n, w_gy_p, w_gy_n, w_ax, w_ay;
  logic [10:0] w_mag;
  logic [7:0]  w_byte;

  assign w_gx_p = {2'b0, r_row0[2]} + {1'b0, r_row1[2], 1'b0} + {2'b0, r_row2[2]};
  assign w_gx_n = {2'b0, r_row0[0]} + {1'b0, r_row1[0], 1'b0} + {2'b0, r_row2[0]};
  assign w_gy_p = {2'b0, r_row2[0]} + {1'b0, r_row2[1], 1'b0} + {2'b0, r_row2[2]};
  assign w_gy_n = {2'b0, r_row0[0]} + {1'b0, r_row0[1], 1'b0} + {2'b0, r_row0[2]};
  assign w_ax   = (w_gx_p >= w_gx_n) ? (w_gx_p - w_gx_n) : (w_gx_n - w_gx_p);
  assign w_ay   = (w_gy_p >= w_gy_n) ? (w_gy_p - w_gy_n) : (w_gy_n - w_gy_p);
  assign w_mag  = {1'b0, w_ax} + {1'b0, w_ay};

  // byte select: border/over-length mask, then binary threshold or saturated magnitude
  always_comb begin
    w_byte = 8'h00;
    if (!r_s2_mask) begin
      if (i_mode) w_byte = (w_mag > 11'd255) ? 8'hFF : w_mag[7:0];
      else        w_byte = (w_mag > i_threshold) ? 8'hFF : 8'h00;
    end
  end

  // stage 3 capture of the finished byte
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s3_vld  <= 1'b0;
      r_s3_eol  <= 1'b0;
      r_s3_sof  <= 1'b0;
      r_s3_byte <= 8'd0;
      r_s3_pos  <= 2'd0;
    end else begin
      r_s3_vld <= r_s2_vld;
      if (r_s2_vld) begin
        r_s3_eol  <= r_s2_eol;
        r_s3_sof  <= r_s2_sof;
        r_s3_byte <= w_byte;
        r_s3_pos  <= r_s2_pos;
      end
    end
  end

  // packing: a frame start drops any partial word left from the previous line
  logic [31:0] w_pack_nxt;
  logic        w_emit;

  assign w_pack_nxt = (r_s3_sof ? 32'd0 : r_pack) | ({24'd0, r_s3_byte} << {r_s3_pos, 3'b000});
  assign w_emit     = r_s3_vld & ((r_s3_pos == 2'd3) | r_s3_eol);

  // pack register and registered word output
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pack     <= 32'd0;
      r_edge_dat <= 32'd0;
      r_edge_vld <= 1'b0;
      r_edge_eol <= 1'b0;
    end else begin
      r_edge_vld <= w_emit;
      r_edge_eol <= w_emit & r_s3_eol;
      if (r_s3_vld) r_pack <= w_emit ? 32'd0 : w_pack_nxt;
      if (w_emit)   r_edge_dat <= w_pack_nxt;
    end
  end

  assign o_edge_dat    = r_edge_dat;
  assign o_edge_vld    = r_edge_vld;
  assign o_edge_eol    = r_edge_eol;
  assign o_over_length = r_over_length;

endmodule

// File: tb/tb_sobel_edge_stream.sv
// Bench for sobel_edge_stream with an 8-pixel maximum line width.
// Directed frames carry hand-derived words; random frames use a 2D Sobel reference.
// A monitor pops expected words (value, end-of-line flag, arrival cycle) on each output pulse.
module tb_sobel_edge_stream;

  localparam int W = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] thr;
  logic        mode;
  logic [7:0]  pix;
  logic        pv, sof, eol;
  logic [31:0] dat;
  logic        vld, weol, over;

  sobel_edge_stream #(.IMG_WIDTH(W)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_threshold  (thr),
    .i_mode       (mode),
    .i_pixel      (pix),
    .i_pixel_vld  (pv),
    .i_sof        (sof),
    .i_eol        (eol),
    .o_edge_dat   (dat),
    .o_edge_vld   (vld),
    .o_edge_eol   (weol),
    .o_over_length(over)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w;
    logic        e;
    int          c;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          n_vld = 0;
  logic [7:0]  lp[16];
  logic [31:0] ew[4];
  logic [7:0]  img[16][16];
  int          frow = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // monitor: every output pulse must match the oldest expected word
  initial begin
    forever begin
      @(negedge clk);
      if (vld) begin
        exp_t e;
        n_vld++;
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_word: got %h while no word was expected (cycle %0d)", dat, cyc);
        end else begin
          e = q.pop_front();
          chk("word", dat, e.w);
          chk("word_eol", {31'd0, weol}, {31'd0, e.e});
          chk("word_cycle", cyc, e.c);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic fill_const(input int len, input logic [7:0] v);
    for (int x = 0; x < len; x++) lp[x] = v;
  endtask

  task automatic fill_step(input int len, input int lo_end);
    for (int x = 0; x < len; x++) lp[x] = (x < lo_end) ? 8'h00 : 8'hFF;
  endtask

  function automatic int px(input int r, input int c);
    return int'(img[r][c]);
  endfunction

  // reference Sobel on the stored frame, output aligned to input position (x,y)
  function automatic logic [7:0] sob(input int x, input int y);
    int gx, gy, mag;
    if (x < 2 || y < 2 || x >= W) return 8'h00;
    gx = (px(y-2, x) + 2*px(y-1, x) + px(y, x)) - (px(y-2, x-2) + 2*px(y-1, x-2) + px(y, x-2));
    gy = (px(y, x-2) + 2*px(y, x-1) + px(y, x)) - (px(y-2, x-2) + 2*px(y-2, x-1) + px(y-2, x));
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (mode) return (mag > 255) ? 8'hFF : 8'(mag);
    return (mag > int'(thr)) ? 8'hFF : 8'h00;
  endfunction

  task automatic model_line(input int len);
    for (int k = 0; k < 4; k++) ew[k] = 32'd0;
    for (int x = 0; x < len; x++) ew[x/4] |= {24'd0, sob(x, frow)} << (8 * (x % 4));
  endtask

  // drive one line from lp[]; expected words come from ew[] (hand values or the model)
  task automatic run_line(input int len, input bit s, input bit eol_end, input int gmax,
                          input bit use_model, input bit expect_out);
    exp_t e;
    if (s) frow = 0;
    if (frow < 16) for (int x = 0; x < len && x < 16; x++) img[frow][x] = lp[x];
    if (use_model) model_line(len);
    for (int x = 0; x < len; x++) begin
      pix = lp[x];
      pv  = 1'b1;
      sof = s && (x == 0);
      eol = eol_end && (x == len - 1);
      if (expect_out && ((x % 4 == 3) || (eol_end && x == len - 1))) begin
        e.w = ew[x/4];
        e.e = eol_end && (x == len - 1);
        e.c = cyc + 4;
        q.push_back(e);
      end
      @(negedge clk);
      pv  = 1'b0;
      sof = 1'b0;
      eol = 1'b0;
      if (gmax > 0) repeat ($urandom_range(gmax, 0)) @(negedge clk);
    end
    frow++;
  endtask

  task automatic step_frame(input int rows);
    for (int r = 0; r < rows; r++) begin
      fill_step(W, 4);
      ew[0] = 32'd0;
      ew[1] = (r >= 2) ? 32'h0000FFFF : 32'd0;
      run_line(W, r == 0, 1'b1, 0, 1'b0, 1'b1);
    end
  endtask

  initial begin
    int nv0, fw, fh;
    pv = 1'b0; sof = 1'b0; eol = 1'b0; pix = 8'd0; mode = 1'b0; thr = 11'd0;
    rst_n = 1'b0;
    idle(3);
    chk("reset_dat", dat, 32'd0);
    chk("reset_vld", {31'd0, vld}, 32'd0);
    chk("reset_eol", {31'd0, weol}, 32'd0);
    chk("reset_over", {31'd0, over}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // flat 0x80 frame, binary mode with threshold 0: all words zero
    mode = 1'b0; thr = 11'd0;
    for (int r = 0; r < 4; r++) begin
      fill_const(W, 8'h80);
      ew[0] = 32'd0; ew[1] = 32'd0;
      run_line(W, r == 0, 1'b1, 0, 1'b0, 1'b1);
    end
    idle(6);

    // vertical step, saturated magnitude: bytes 4,5 = 255 on rows >= 2
    mode = 1'b1;
    step_frame(4);
    idle(6);

    // vertical step, binary: magnitude 1020 is above 1019 but not above 1020
    mode = 1'b0; thr = 11'd1019;
    step_frame(3);
    idle(6);
    thr = 11'd1020;
    for (int r = 0; r < 3; r++) begin
      fill_step(W, 4);
      ew[0] = 32'd0; ew[1] = 32'd0;
      run_line(W, r == 0, 1'b1, 0, 1'b0, 1'b1);
    end
    idle(6);

    // 6-pixel lines: second word holds bytes 4,5 only, upper bytes zero
    mode = 1'b1;
    for (int r = 0; r < 3; r++) begin
      fill_step(6, 4);
      ew[0] = 32'd0;
      ew[1] = (r >= 2) ? 32'h0000FFFF : 32'd0;
      run_line(6, r == 0, 1'b1, 0, 1'b0, 1'b1);
    end
    idle(6);

    // over-length: third row carries 10 pixels, bytes 8,9 forced to zero
    for (int r = 0; r < 2; r++) begin
      fill_step(W, 4);
      ew[0] = 32'd0; ew[1] = 32'd0;
      run_line(W, r == 0, 1'b1, 0, 1'b0, 1'b1);
    end
    chk("over_before", {31'd0, over}, 32'd0);
    fill_step(10, 4);
    ew[0] = 32'd0; ew[1] = 32'h0000FFFF; ew[2] = 32'd0;
    run_line(10, 1'b0, 1'b1, 0, 1'b0, 1'b1);
    idle(6);
    chk("over_set", {31'd0, over}, 32'd1);

    // one-pixel line (sof+eol together); next lines are rows 1 and 2
    lp[0] = 8'h00; ew[0] = 32'd0;
    run_line(1, 1'b1, 1'b1, 0, 1'b0, 1'b1);
    chk("over_cleared", {31'd0, over}, 32'd0);
    fill_step(W, 4); ew[0] = 32'd0; ew[1] = 32'd0;
    run_line(W, 1'b0, 1'b1, 0, 1'b0, 1'b1);
    fill_step(W, 4); ew[0] = 32'd0; ew[1] = 32'h0000FFFF;
    run_line(W, 1'b0, 1'b1, 0, 1'b0, 1'b1);
    idle(6);

    // reset mid row 3, then pixels without a frame start are ignored
    step_frame(3);
    fill_step(2, 4);
    run_line(2, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    idle(3);
    chk("pre_reset_dat", dat, 32'h0000FFFF);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_dat", dat, 32'd0);
    chk("mid_reset_vld", {31'd0, vld}, 32'd0);
    chk("mid_reset_eol", {31'd0, weol}, 32'd0);
    chk("mid_reset_over", {31'd0, over}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    nv0 = n_vld;
    fill_step(W, 4);
    run_line(W, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    idle(6);
    chk("ignored_words", n_vld - nv0, 0);
    step_frame(3);

    // partial line then an immediate frame start: the partial word is dropped
    fill_step(6, 4);
    ew[0] = 32'd0;
    run_line(6, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    step_frame(3);
    idle(6);

    // random frames with gaps against the reference model
    for (int f = 0; f < 4; f++) begin
      mode = 1'($urandom_range(1, 0));
      thr  = 11'($urandom_range(600, 0));
      fw   = $urandom_range(W, 3);
      fh   = $urandom_range(7, 3);
      for (int r = 0; r < fh; r++) begin
        for (int x = 0; x < fw; x++) lp[x] = 8'($urandom_range(255, 0));
        run_line(fw, r == 0, 1'b1, 3, 1'b1, 1'b1);
      end
      idle(6);
    end

    idle(10);
    chk("outstanding_words", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit with %0d words outstanding", q.size());
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp + 1, n_bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
